// File: rtl/fifo2gmii.sv
// Drains 72-bit masked words from a FWFT port FIFO onto GMII: preamble, SFD, payload bytes,
// then an inter-frame gap. An underrun marks the frame with tx_er and discards its remainder.
module fifo2gmii #(
  parameter int unsigned IFG_BYTES    = 12,
  parameter int unsigned PREAMBLE_LEN = 7
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [71:0] dout,
  input  logic        empty,
  output logic        rd_en,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [31:0] tx_frames,
  output logic [15:0] tx_underruns
);

  typedef enum logic [2:0] {StIdle, StPreamble, StSfd, StData, StDrop, StIfg} state_e;

  state_e      state;
  logic [2:0]  lane;
  logic [3:0]  pre_cnt;
  logic [7:0]  ifg_cnt;

  logic [7:0]  mask;
  logic [63:0] data;
  logic [3:0]  nvalid;
  logic        run;
  logic        last_lane;
  logic        is_last_word;
  logic        ifg_done;
  logic [7:0]  cur_byte;

  assign mask         = dout[71:64];
  assign data         = dout[63:0];
  assign is_last_word = (mask != 8'hFF);
  assign cur_byte     = data[{~lane, 3'b000} +: 8];
  assign last_lane    = (({1'b0, lane} + 4'd1) == nvalid);
  // ifg_cnt counts idle wire cycles already committed; the IDLE cycle supplies the final one.
  assign ifg_done     = (({1'b0, ifg_cnt} + 9'd2) >= 9'(IFG_BYTES));

  // Valid bytes are the leading ones of the mask; anything after the first zero is ignored.
  always_comb begin
    nvalid = 4'd0;
    run    = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      run    = run & mask[i];
      nvalid = nvalid + {3'b000, run};
    end
  end

  always_comb begin
    rd_en = 1'b0;
    if (sys_rst && !empty) begin
      unique case (state)
        StIdle:  rd_en = (mask == 8'h00);
        StData:  rd_en = (nvalid == 4'd0) || last_lane;
        StDrop:  rd_en = 1'b1;
        default: rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state        <= StIdle;
      lane         <= 3'd0;
      pre_cnt      <= 4'd0;
      ifg_cnt      <= 8'd0;
      gmii_txd     <= 8'h00;
      gmii_tx_en   <= 1'b0;
      gmii_tx_er   <= 1'b0;
      tx_frames    <= 32'd0;
      tx_underruns <= 16'd0;
    end else begin
      gmii_tx_er <= 1'b0;
      unique case (state)
        StIdle: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (!empty && (mask != 8'h00)) begin
            state   <= StPreamble;
            pre_cnt <= 4'd0;
          end
        end
        StPreamble: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= 8'h55;
          if (pre_cnt == 4'(PREAMBLE_LEN - 1)) begin
            state   <= StSfd;
            pre_cnt <= 4'd0;
          end else begin
            pre_cnt <= pre_cnt + 4'd1;
          end
        end
        StSfd: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= 8'hD5;
          lane       <= 3'd0;
          state      <= StData;
        end
        StData: begin
          if (empty) begin
            gmii_tx_en   <= 1'b1;
            gmii_tx_er   <= 1'b1;
            gmii_txd     <= 8'h00;
            tx_underruns <= tx_underruns + 16'd1;
            lane         <= 3'd0;
            state        <= StDrop;
          end else if (nvalid == 4'd0) begin
            // Terminator: consumed in a dead cycle, which already counts toward the gap.
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            tx_frames  <= tx_frames + 32'd1;
            lane       <= 3'd0;
            ifg_cnt    <= 8'd1;
            state      <= StIfg;
          end else begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= cur_byte;
            if (last_lane) begin
              lane <= 3'd0;
              if (is_last_word) begin
                tx_frames <= tx_frames + 32'd1;
                ifg_cnt   <= 8'd0;
                state     <= StIfg;
              end
            end else begin
              lane <= lane + 3'd1;
            end
          end
        end
        StDrop: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (!empty && is_last_word) begin
            ifg_cnt <= 8'd1;
            state   <= StIfg;
          end
        end
        StIfg: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (ifg_done) begin
            ifg_cnt <= 8'd0;
            state   <= StIdle;
          end else begin
            ifg_cnt <= ifg_cnt + 8'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo2gmii.sv
// Bench for fifo2gmii: a queue-backed FWFT FIFO feeds the DUT and every GMII cycle is logged
// and compared with a wire stream built from payload bytes, preamble length and gap length.
module tb_fifo2gmii;

  localparam int unsigned IFG = 12;
  localparam int unsigned PRE = 7;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [71:0] dout;
  logic        empty;
  logic        rd_en;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic [31:0] tx_frames;
  logic [15:0] tx_underruns;

  fifo2gmii #(
    .IFG_BYTES   (IFG),
    .PREAMBLE_LEN(PRE)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .dout        (dout),
    .empty       (empty),
    .rd_en       (rd_en),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .tx_frames   (tx_frames),
    .tx_underruns(tx_underruns)
  );

  always #4 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0]  mask;
    logic [63:0] data;
    int          nbytes;
    int          npops;
  } vec_t;

  logic [71:0] fifo_q[$];
  logic [71:0] hold_q[$];
  logic [9:0]  wlog[$];   // {tx_en, tx_er, txd} after each rising edge
  logic [9:0]  exp_q[$];
  logic [7:0]  pay[$];
  vec_t        vt[8];

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int rd_viol = 0;
  int exp_frames = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  task automatic refresh();
    if (fifo_q.size() > 0) begin
      dout  = fifo_q[0];
      empty = 1'b0;
    end else begin
      dout  = {8'($urandom), $urandom, $urandom};
      empty = 1'b1;
    end
  endtask

  task automatic tick();
    logic do_pop;
    #1;
    if (rd_en && empty) rd_viol++;
    do_pop = rd_en && !empty;
    @(posedge sys_clk);
    #1;
    if (do_pop) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    refresh();
    wlog.push_back({gmii_tx_en, gmii_tx_er, gmii_txd});
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Pack pay[] into FIFO words: full words, then a partial last word or a terminator.
  task automatic push_payload();
    int n;
    int idx;
    int r;
    logic [71:0] w;
    logic [7:0] ones;
    logic [7:0] junk;
    n   = pay.size();
    idx = 0;
    while (n - idx >= 8) begin
      w[71:64] = 8'hFF;
      for (int l = 0; l < 8; l++) w[63-8*l -: 8] = pay[idx+l];
      fifo_q.push_back(w);
      idx += 8;
    end
    r = n - idx;
    w = {8'($urandom), $urandom, $urandom};
    if (r == 0) begin
      w[71:64] = 8'h00;
    end else begin
      ones     = 8'hFF << (8 - r);
      junk     = (8'h01 << (7 - r)) - 8'h01;
      w[71:64] = ones | (8'($urandom) & junk);
      for (int l = 0; l < r; l++) w[63-8*l -: 8] = pay[idx+l];
    end
    fifo_q.push_back(w);
  endtask

  task automatic rand_payload(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(10'h000);
  endtask

  task automatic add_frame_exp();
    repeat (PRE) exp_q.push_back({2'b10, 8'h55});
    exp_q.push_back({2'b10, 8'hD5});
    foreach (pay[i]) exp_q.push_back({2'b10, pay[i]});
  endtask

  // Compare the log with exp_q placed at 'start' (-1: at the first tx_en); all else must idle.
  task automatic check_stream(input string name, input int start_in);
    int bad;
    int first;
    int start;
    logic [9:0] e;
    bad   = 0;
    first = -1;
    start = start_in;
    if (start < 0) begin
      foreach (wlog[i]) if (start < 0 && wlog[i][9]) start = i;
      if (start < 0) begin
        bad   = 1;
        start = 0;
      end
    end
    foreach (wlog[i]) begin
      e = (i >= start && (i - start) < exp_q.size()) ? exp_q[i-start] : 10'h000;
      if (wlog[i] !== e) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (wlog.size() < start + exp_q.size()) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      if (first >= 0)
        $display("FAIL %s: %0d bad cycles, first at %0d got %0h expected %0h", name, bad,
                 first, wlog[first], ((first >= start && (first - start) < exp_q.size()) ?
                 exp_q[first-start] : 10'h000));
      else
        $display("FAIL %s: log has %0d cycles, required at least %0d", name, wlog.size(),
                 start + exp_q.size());
    end
  endtask

  task automatic begin_case();
    wlog.delete();
    exp_q.delete();
    pops = 0;
  endtask

  initial begin
    int fall;
    int rise;
    int txc;
    int found;
    int total;
    int epops;
    int len;
    logic [63:0] d;

    sys_rst = 1'b0;
    refresh();
    run(3);

    // Reset state, with a terminator waiting that must not be popped
    fifo_q.push_back({8'h00, 64'h0123_4567_89AB_CDEF});
    refresh();
    #1;
    check("reset_rd_en", rd_en, 0);
    check("reset_tx_en", gmii_tx_en, 0);
    check("reset_tx_er", gmii_tx_er, 0);
    check("reset_txd", gmii_txd, 0);
    check("reset_frames", tx_frames, 0);
    check("reset_underruns", tx_underruns, 0);
    fifo_q.delete();
    refresh();
    #1 sys_rst = 1'b1;
    run(3);

    // Stray terminator in IDLE
    begin_case();
    fifo_q.push_back({8'h00, 64'hFEED_FACE_CAFE_BEEF});
    refresh();
    run(6);
    check("stray_pops", pops, 1);
    check_stream("stray_stream", 0);
    check("stray_frames", tx_frames, 0);
    check("stray_underruns", tx_underruns, 0);

    // Single-word frames: leading-ones mask decode
    vt[0] = '{8'h80, 64'hA1B2_C3D4_E5F6_0718, 1, 1};
    vt[1] = '{8'hC0, 64'h1122_3344_5566_7788, 2, 1};
    vt[2] = '{8'hE3, 64'h99AA_BBCC_DDEE_FF00, 3, 1};
    vt[3] = '{8'hF0, 64'h0F1E_2D3C_4B5A_6978, 4, 1};
    vt[4] = '{8'hFE, 64'h8796_A5B4_C3D2_E1F0, 7, 1};
    vt[5] = '{8'hFF, 64'h5A5A_A5A5_3C3C_C3C3, 8, 2};
    vt[6] = '{8'hA5, 64'h7E00_1234_5678_9ABC, 1, 1};
    vt[7] = '{8'h9F, 64'hC001_D00D_0BAD_F00D, 1, 1};
    for (int k = 0; k < 8; k++) begin
      begin_case();
      fifo_q.push_back({vt[k].mask, vt[k].data});
      if (vt[k].mask == 8'hFF) fifo_q.push_back({8'h00, 64'h0});
      refresh();
      run(40);
      d = vt[k].data;
      pay.delete();
      for (int b = 0; b < vt[k].nbytes; b++) pay.push_back(d[63-8*b -: 8]);
      add_idle(1);
      add_frame_exp();
      exp_frames++;
      check_stream($sformatf("vec%0d_stream", k), 0);
      check($sformatf("vec%0d_pops", k), pops, vt[k].npops);
      check($sformatf("vec%0d_frames", k), tx_frames, exp_frames);
    end

    // 64-byte frame closed by a terminator
    begin_case();
    rand_payload(64);
    push_payload();
    refresh();
    run(100);
    add_idle(1);
    add_frame_exp();
    exp_frames++;
    check_stream("f64_stream", 0);
    check("f64_pops", pops, 9);
    check("f64_frames", tx_frames, exp_frames);

    // 60-byte frame closed by a partial word
    begin_case();
    rand_payload(60);
    push_payload();
    refresh();
    run(100);
    add_idle(1);
    add_frame_exp();
    exp_frames++;
    check_stream("f60_stream", 0);
    check("f60_pops", pops, 8);
    check("f60_frames", tx_frames, exp_frames);

    // Two back-to-back preloaded frames
    begin_case();
    rand_payload(64);
    push_payload();
    add_idle(1);
    add_frame_exp();
    add_idle(IFG);
    rand_payload(64);
    push_payload();
    add_frame_exp();
    refresh();
    run(1 + 72 + IFG + 72 + IFG + 10);
    exp_frames += 2;
    check_stream("b2b_stream", 0);
    fall = -1;
    rise = -1;
    for (int i = 1; i < wlog.size(); i++) begin
      if (fall < 0 && wlog[i-1][9] && !wlog[i][9]) fall = i;
      if (fall >= 0 && rise < 0 && !wlog[i-1][9] && wlog[i][9]) rise = i;
    end
    check("b2b_gap", rise - fall, IFG);
    check("b2b_pops", pops, 18);
    check("b2b_frames", tx_frames, exp_frames);

    // Underrun after the third word, then refill plus a following good frame
    begin_case();
    rand_payload(48);
    push_payload();
    hold_q.delete();
    while (fifo_q.size() > 3) hold_q.push_front(fifo_q.pop_back());
    refresh();
    run(60);
    while (pay.size() > 24) void'(pay.pop_back());
    add_idle(1);
    add_frame_exp();
    exp_q.push_back(10'h300);
    check_stream("ur_stream", 0);
    check("ur_pops", pops, 3);
    check("ur_underruns", tx_underruns, 1);
    check("ur_frames", tx_frames, exp_frames);
    begin_case();
    foreach (hold_q[i]) fifo_q.push_back(hold_q[i]);
    rand_payload(30);
    push_payload();
    refresh();
    run(100);
    add_frame_exp();
    exp_frames++;
    check_stream("ur_next_stream", -1);
    check("ur_drain_pops", pops, 8);
    check("ur_underruns_after", tx_underruns, 1);
    check("ur_next_frames", tx_frames, exp_frames);
    check("ur_fifo_empty", fifo_q.size(), 0);

    // Reset pulse while payload byte 20 is on the wire
    begin_case();
    rand_payload(40);
    push_payload();
    refresh();
    txc   = 0;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      tick();
      if (gmii_tx_en) txc++;
      if (txc == PRE + 1 + 21) found = 1;
    end
    check("rst_reach_byte20", found, 1);
    check("rst_byte20_value", gmii_txd, pay[20]);
    #1 sys_rst = 1'b0;
    #1;
    check("rst_tx_en_async", gmii_tx_en, 0);
    check("rst_txd", gmii_txd, 0);
    check("rst_tx_er", gmii_tx_er, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_frames", tx_frames, 0);
    check("rst_underruns", tx_underruns, 0);
    exp_frames = 0;
    run(2);
    check("rst_no_pop", fifo_q.size(), 4);
    #1 sys_rst = 1'b1;
    begin_case();
    run(60);
    repeat (16) void'(pay.pop_front());
    add_idle(1);
    add_frame_exp();
    exp_frames++;
    check_stream("rst_resume_stream", 0);
    check("rst_resume_pops", pops, 4);
    check("rst_resume_frames", tx_frames, exp_frames);

    // Randomized preloaded frame trains
    for (int rnd = 0; rnd < 3; rnd++) begin
      begin_case();
      add_idle(1);
      total = 1;
      epops = 0;
      for (int f = 0; f < 5; f++) begin
        len = $urandom_range(70, 1);
        rand_payload(len);
        push_payload();
        add_frame_exp();
        if (f < 4) add_idle(IFG);
        epops += len / 8 + 1;
        total += PRE + 1 + len + IFG;
      end
      refresh();
      run(total + 20);
      exp_frames += 5;
      check_stream($sformatf("rand%0d_stream", rnd), 0);
      check($sformatf("rand%0d_pops", rnd), pops, epops);
      check($sformatf("rand%0d_frames", rnd), tx_frames, exp_frames);
      check($sformatf("rand%0d_fifo_empty", rnd), fifo_q.size(), 0);
    end

    check("rd_en_while_empty", rd_viol, 0);
    check("final_underruns", tx_underruns, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo2gmii.md
FIFO2GMII -- requirements
Module: fifo2gmii

Interface
REQ-001 The block SHALL expose parameter IFG_BYTES, default 12, giving the minimum idle cycles between frames (range 1-255).
REQ-002 The block SHALL expose parameter PREAMBLE_LEN, default 7, giving the count of 0x55 bytes before the SFD (range 1-15).
REQ-003 sys_clk  input  1  125 MHz transmit clock; the only clock, all logic on its rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-low reset.
REQ-005 dout  input  72  head word of a first-word-fall-through port FIFO; valid whenever empty=0.
REQ-006 empty  input  1  port FIFO empty flag.
REQ-007 rd_en  output  1  pops the head word; single-cycle pulse per word.
REQ-008 gmii_txd  output  8  transmit data byte (registered).
REQ-009 gmii_tx_en  output  1  transmit enable (registered).
REQ-010 gmii_tx_er  output  1  transmit error (registered).
REQ-011 tx_frames  output  32  count of frames completed without error.
REQ-012 tx_underruns  output  16  count of frames aborted by underrun.

Function
REQ-013 Word format SHALL be: dout[71:64] byte-valid mask, dout[63:0] data, byte 0 in [63:56], byte 7 in [7:0]; mask bit 7 qualifies byte 0.
REQ-014 Valid bytes in a word SHALL be the count of leading ones of the mask; bits after the first zero SHALL be ignored.
REQ-015 A word with mask 8'hFF SHALL be a mid-frame word; any other mask SHALL mark the last word of a frame, including mask 8'h00 (terminator carrying no bytes).
REQ-016 FIFO frames SHALL contain destination MAC through FCS; the block SHALL NOT generate or check FCS.
REQ-017 States SHALL be IDLE, PREAMBLE, SFD, DATA, DROP, IFG.
REQ-018 IDLE: on empty=0 with mask!=0, enter PREAMBLE; on empty=0 with mask=0, pop the word (rd_en=1) and remain IDLE.
REQ-019 PREAMBLE: output 0x55 with tx_en=1 for PREAMBLE_LEN cycles; then SFD outputs 0xD5 for one cycle; then DATA.
REQ-020 Latency: gmii_tx_en SHALL rise on the second rising edge after empty falls in IDLE (one cycle of state transition, one of output register).
REQ-021 DATA: one byte per cycle from the head word in lane order; rd_en SHALL pulse in the cycle the last valid byte of the head word is loaded into the output register.
REQ-022 After popping a mid-frame word, if empty=0 the next byte SHALL come from the new head word with no gap cycle.
REQ-023 After popping a last word, enter IFG, increment tx_frames by 1; a terminator (mask 0) reached in DATA SHALL be popped in one cycle with tx_en low that cycle and the frame ended.
REQ-024 Underrun: in DATA, needing a new word while empty=1, the block SHALL output one cycle tx_en=1, tx_er=1, txd=0x00, increment tx_underruns, and enter DROP.
REQ-025 DROP: pop words as they become available (rd_en=1 when empty=0) until a last word is popped, then enter IFG; tx_en=0 throughout.
REQ-026 IFG: hold tx_en=0, tx_er=0, txd=0x00 for IFG_BYTES cycles, then IDLE; FIFO state SHALL be ignored during IFG.
REQ-027 rd_en SHALL never be 1 while empty=1.
REQ-028 Counters SHALL wrap modulo 2^32 and 2^16 respectively.
REQ-029 gmii_tx_er SHALL be 0 in every cycle other than REQ-024.

Reset
REQ-030 While sys_rst=0: state=IDLE, rd_en=0, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, tx_frames=0, tx_underruns=0, lane index=0, IFG counter=0.
REQ-031 Reset asserted mid-frame SHALL drop tx_en immediately (asynchronously), discard any partly sent word without popping it, and resume in IDLE on release.
REQ-032 First frame after reset release SHALL start without an IFG wait.

Verification
REQ-033 Single frame of 64 bytes (8 words mask FF, then terminator mask 00) -> 7x0x55, 0xD5, 64 data bytes contiguous, tx_en high 72 cycles, 8+1 rd_en pulses, tx_frames=1.
REQ-034 60-byte frame (7 words FF, last word mask F0) -> 68 tx_en cycles, last four bytes = dout[63:32] of last word, 8 rd_en pulses, no terminator consumed.
REQ-035 Two back-to-back frames preloaded -> exactly 12 idle cycles between tx_en fall and rise, tx_frames=2.
REQ-036 Underrun: empty forced 1 after third word of a frame -> one cycle tx_en=1 tx_er=1 txd=00, then tx_en=0; remaining words popped on refill; tx_underruns=1, tx_frames=0; next frame transmits normally.
REQ-037 Stray terminator (mask 00) at head in IDLE -> popped in one cycle, tx_en stays 0, counters unchanged.
REQ-038 sys_rst pulsed low during DATA byte 20 -> tx_en low in the same cycle, outputs at reset values, head word not popped; after release the remaining FIFO contents resume from IDLE.
